// File: rtl/regfile_write_sched.sv
// regfile_write_sched: single-write-port scheduler for the 4x8 register file.
// Arbitrates one register-file write per cycle between three sources, highest
// priority first: RAM load returns, ALU results, then register ops
// (LOADIMM/MOV/IN). A per-register busy scoreboard tracks loads in flight and
// drives the WAW/RAW stalls.
// Optional feature macro: SCHED_FWD_EN. When it is defined, an OUT op whose
// source is busy only because its load returns this cycle takes ram_data
// directly. When it is undefined, that OUT stalls one cycle and reads the
// register file afterwards.
module regfile_write_sched #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  // ALU result write request
  input  logic                     alu_we,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_stall,
  // Load issue and RAM return data
  input  logic                     ld_req,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_stall,
  input  logic [DATA_W-1:0]        ram_data,
  // Register ops
  input  logic                     op_valid,
  input  logic [1:0]               op_code,
  input  logic [ADDR_W-1:0]        op_dst,
  input  logic [ADDR_W-1:0]        op_src,
  input  logic [DATA_W-1:0]        imm,
  input  logic [DATA_W-1:0]        in_term,
  output logic                     op_stall,
  // Register file ports
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  // Scoreboard and terminal output
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic [DATA_W-1:0]        out_term,
  output logic                     out_valid
);

  localparam int NREG = 1 << ADDR_W;

  localparam logic [1:0] OP_LOADIMM = 2'b00;
  localparam logic [1:0] OP_MOV     = 2'b01;
  localparam logic [1:0] OP_OUT     = 2'b10;
  localparam logic [1:0] OP_IN      = 2'b11;

  // Only latencies 1..3 are supported by the RAM interface.
  if ((LOAD_LAT < 1) || (LOAD_LAT > 3)) begin : gLatCheck
    $error("regfile_write_sched: LOAD_LAT must be 1..3");
  end

  // Load pipeline: stage 0 holds the load accepted on the previous edge;
  // the last stage is the load whose data is on ram_data this cycle.
  logic [LOAD_LAT-1:0] pipeValid;
  logic [ADDR_W-1:0]   pipeAddr [LOAD_LAT];

  logic                retValid;
  logic [ADDR_W-1:0]   retAddr;

  logic                ldTake;
  logic                aluTake;
  logic                isOut;
  logic                usesSrc;
  logic                usesDst;
  logic                srcBlocked;
  logic                opTakeWrite;
  logic                opTakeOut;
  logic                outFwd;
  logic [DATA_W-1:0]   outNext;
  logic [DATA_W-1:0]   opWrData;
  logic [NREG-1:0]     busySetMask;
  logic [NREG-1:0]     busyClrMask;

  assign retValid = pipeValid[LOAD_LAT-1];
  assign retAddr  = pipeAddr[LOAD_LAT-1];
  assign rd_addr  = op_src;

  // Decode the register-op class: which ops read op_src and which write op_dst.
  always_comb begin
    isOut   = 1'b0;
    usesSrc = 1'b0;
    usesDst = 1'b0;
    case (op_code)
      OP_LOADIMM: begin
        usesDst = 1'b1;
      end
      OP_MOV: begin
        usesSrc = 1'b1;
        usesDst = 1'b1;
      end
      OP_OUT: begin
        isOut   = 1'b1;
        usesSrc = 1'b1;
      end
      OP_IN: begin
        usesDst = 1'b1;
      end
      default: begin
        isOut   = 1'b0;
        usesSrc = 1'b0;
        usesDst = 1'b0;
      end
    endcase
  end

  // An OUT reading a register whose load lands this very cycle may forward
  // ram_data; MOV never forwards because the load owns the write port.
  always_comb begin
    outFwd = 1'b0;
`ifdef SCHED_FWD_EN
    if (isOut && retValid && (retAddr == op_src)) begin
      outFwd = 1'b1;
    end else begin
      outFwd = 1'b0;
    end
`endif
    srcBlocked = busy[op_src] && !outFwd;
  end

  // Stall generation: hazards against the scoreboard, then write-port priority.
  always_comb begin
    ld_stall  = ld_req && busy[ld_addr];
    ldTake    = ld_req && !ld_stall;

    // Load return always wins the port; a busy destination is a WAW hazard.
    alu_stall = alu_we && (retValid || busy[alu_addr]);
    aluTake   = alu_we && !alu_stall;

    op_stall  = op_valid &&
                ((usesSrc && srcBlocked) ||
                 (usesDst && (busy[op_dst] || retValid || aluTake)));
    opTakeWrite = op_valid && !op_stall && usesDst;
    opTakeOut   = op_valid && !op_stall && isOut;
  end

  // Data an accepted register op writes into the register file.
  always_comb begin
    opWrData = {DATA_W{1'b0}};
    case (op_code)
      OP_LOADIMM: opWrData = imm;
      OP_MOV:     opWrData = rd_data;
      OP_IN:      opWrData = in_term;
      default:    opWrData = {DATA_W{1'b0}};
    endcase
  end

  // Write-port mux: load return, then ALU, then register op; idle drives zeros.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = {ADDR_W{1'b0}};
    wr_data = {DATA_W{1'b0}};
    if (retValid) begin
      wr_en   = 1'b1;
      wr_addr = retAddr;
      wr_data = ram_data;
    end else if (aluTake) begin
      wr_en   = 1'b1;
      wr_addr = alu_addr;
      wr_data = alu_data;
    end else if (opTakeWrite) begin
      wr_en   = 1'b1;
      wr_addr = op_dst;
      wr_data = opWrData;
    end else begin
      wr_en   = 1'b0;
      wr_addr = {ADDR_W{1'b0}};
      wr_data = {DATA_W{1'b0}};
    end
  end

  // Scoreboard update masks: set on load accept, clear as the load returns.
  always_comb begin
    busySetMask = {NREG{1'b0}};
    busyClrMask = {NREG{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      busySetMask[r] = ldTake && (ld_addr == ADDR_W'(r));
      busyClrMask[r] = retValid && (retAddr == ADDR_W'(r));
    end
  end

  // Value captured into out_term when an OUT is taken.
  always_comb begin
    if (outFwd) begin
      outNext = ram_data;
    end else begin
      outNext = rd_data;
    end
  end

  // Load pipeline shift; reset drops every in-flight load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipeValid <= {LOAD_LAT{1'b0}};
      for (int i = 0; i < LOAD_LAT; i++) begin
        pipeAddr[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      pipeValid[0] <= ldTake;
      pipeAddr[0]  <= ld_addr;
      for (int i = 1; i < LOAD_LAT; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeAddr[i]  <= pipeAddr[i-1];
      end
    end
  end

  // Busy scoreboard register; a register cannot be both set and cleared in one
  // cycle because a busy destination stalls the new load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= {NREG{1'b0}};
    end else begin
      busy <= (busy & ~busyClrMask) | busySetMask;
    end
  end

  // OUT terminal register and its one-cycle update pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_term  <= {DATA_W{1'b0}};
      out_valid <= 1'b0;
    end else begin
      out_valid <= opTakeOut;
      if (opTakeOut) begin
        out_term <= outNext;
      end else begin
        out_term <= out_term;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Scoreboard bench for regfile_write_sched, built with LOAD_LAT=2.
// Expected writes and OUT results are queued as stimulus is issued; a monitor
// pops and compares whenever wr_en or out_valid is seen.
module tb_regfile_write_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_we;
  logic [1:0] alu_addr;
  logic [7:0] alu_data;
  logic       alu_stall;
  logic       ld_req;
  logic [1:0] ld_addr;
  logic       ld_stall;
  logic [7:0] ram_data;
  logic       op_valid;
  logic [1:0] op_code;
  logic [1:0] op_dst;
  logic [1:0] op_src;
  logic [7:0] imm;
  logic [7:0] in_term;
  logic       op_stall;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] busy;
  logic [7:0] out_term;
  logic       out_valid;

  typedef struct packed {
    logic [1:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wrQ[$];
  logic [7:0] outQ[$];
  logic [7:0] rf [4];
  int         checks = 0;
  int         errors = 0;

  regfile_write_sched #(.DATA_W(8), .ADDR_W(2), .LOAD_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_addr(alu_addr), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_stall(ld_stall), .ram_data(ram_data),
    .op_valid(op_valid), .op_code(op_code), .op_dst(op_dst), .op_src(op_src),
    .imm(imm), .in_term(in_term), .op_stall(op_stall),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .out_term(out_term), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Register file model: old value visible on a same-cycle write.
  assign rd_data = rf[rd_addr];
  always @(posedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented write and OUT pulse with the queues.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wrQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got r%0d=%0h expected no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = wrQ.pop_front();
        chk("wr_addr", {30'd0, wr_addr}, {30'd0, e.a});
        chk("wr_data", {24'd0, wr_data}, {24'd0, e.d});
      end
    end
    if (out_valid === 1'b1) begin
      if (outQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got out_term=%0h expected no pulse", out_term);
      end else begin
        logic [7:0] eo;
        eo = outQ.pop_front();
        chk("out_term", {24'd0, out_term}, {24'd0, eo});
      end
    end
  end

  task automatic idle();
    alu_we = 1'b0; alu_addr = 2'd0; alu_data = 8'h00;
    ld_req = 1'b0; ld_addr = 2'd0; ram_data = 8'hFF;
    op_valid = 1'b0; op_code = 2'b00; op_dst = 2'd0; op_src = 2'd0;
    imm = 8'h00; in_term = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWr(input logic [1:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wrQ.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", {28'd0, busy}, 32'd0);
    chk("rst_out_term", {24'd0, out_term}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {30'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    tick();
    rst = 1'b0;

    // 1. LOADIMM r2=A5 on an idle port.
    op_valid = 1'b1; op_code = 2'b00; op_dst = 2'd2; imm = 8'hA5;
    pushWr(2'd2, 8'hA5);
    @(negedge clk); chk("t1_op_stall", {31'd0, op_stall}, 32'd0);
    tick(); idle();

    // 2. ALU r1=11 beats IN r3=7E; IN lands next cycle.
    alu_we = 1'b1; alu_addr = 2'd1; alu_data = 8'h11;
    op_valid = 1'b1; op_code = 2'b11; op_dst = 2'd3; in_term = 8'h7E;
    pushWr(2'd1, 8'h11);
    @(negedge clk);
    chk("t2_alu_stall", {31'd0, alu_stall}, 32'd0);
    chk("t2_op_stall_c0", {31'd0, op_stall}, 32'd1);
    tick();
    alu_we = 1'b0;
    pushWr(2'd3, 8'h7E);
    @(negedge clk); chk("t2_op_stall_c1", {31'd0, op_stall}, 32'd0);
    tick(); idle();

    // 3. Load r1 (latency 2) collides with ALU r3 in the return cycle.
    ld_req = 1'b1; ld_addr = 2'd1;
    @(negedge clk);
    chk("t3_ld_stall", {31'd0, ld_stall}, 32'd0);
    chk("t3_busy_c0", {28'd0, busy}, 32'd0);
    tick(); idle();
    alu_we = 1'b1; alu_addr = 2'd1; alu_data = 8'h99;
    ld_req = 1'b1; ld_addr = 2'd1;
    op_valid = 1'b1; op_code = 2'b01; op_dst = 2'd0; op_src = 2'd1;
    @(negedge clk);
    chk("t3_busy_c1", {28'd0, busy}, 32'h2);
    chk("t3_waw_alu_stall", {31'd0, alu_stall}, 32'd1);
    chk("t3_ld_hazard_stall", {31'd0, ld_stall}, 32'd1);
    chk("t3_raw_mov_stall", {31'd0, op_stall}, 32'd1);
    tick(); idle();
    ram_data = 8'h3C;
    alu_we = 1'b1; alu_addr = 2'd3; alu_data = 8'h44;
    pushWr(2'd1, 8'h3C);
    @(negedge clk);
    chk("t3_alu_stall_ret", {31'd0, alu_stall}, 32'd1);
    chk("t3_busy_c2", {28'd0, busy}, 32'h2);
    tick();
    ram_data = 8'hFF;
    pushWr(2'd3, 8'h44);
    @(negedge clk);
    chk("t3_alu_stall_c3", {31'd0, alu_stall}, 32'd0);
    chk("t3_busy_c3", {28'd0, busy}, 32'd0);
    tick(); idle();

    // 4. Load r0=5A, OUT r0 in the return cycle.
    ld_req = 1'b1; ld_addr = 2'd0;
    tick(); idle();
    tick();
    ram_data = 8'h5A;
    op_valid = 1'b1; op_code = 2'b10; op_src = 2'd0;
    pushWr(2'd0, 8'h5A);
`ifdef SCHED_FWD_EN
    outQ.push_back(8'h5A);
    @(negedge clk); chk("t4_out_fwd_stall", {31'd0, op_stall}, 32'd0);
    tick(); idle();
`else
    @(negedge clk); chk("t4_out_stall_ret", {31'd0, op_stall}, 32'd1);
    tick();
    ram_data = 8'hFF;
    outQ.push_back(8'h5A);
    @(negedge clk); chk("t4_out_stall_after", {31'd0, op_stall}, 32'd0);
    tick(); idle();
`endif
    tick();
    @(negedge clk); chk("t4_out_term_hold", {24'd0, out_term}, 32'h5A);
    tick();

    // 5. Load r2, then reset before it returns: nothing is written.
    ld_req = 1'b1; ld_addr = 2'd2;
    tick(); idle();
    @(negedge clk); chk("t5_busy_before", {28'd0, busy}, 32'h4);
    tick();
    rst = 1'b1;
    @(negedge clk); chk("t5_busy_rst", {28'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    ram_data = 8'hEE;
    @(negedge clk); chk("t5_wr_en_dropped", {31'd0, wr_en}, 32'd0);
    tick(); idle();

    // 6. r1=10, then ALU r1=22 alongside OUT r1 reads the old 10.
    op_valid = 1'b1; op_code = 2'b00; op_dst = 2'd1; imm = 8'h10;
    pushWr(2'd1, 8'h10);
    tick(); idle();
    alu_we = 1'b1; alu_addr = 2'd1; alu_data = 8'h22;
    op_valid = 1'b1; op_code = 2'b10; op_src = 2'd1;
    pushWr(2'd1, 8'h22);
    outQ.push_back(8'h10);
    @(negedge clk);
    chk("t6_alu_stall", {31'd0, alu_stall}, 32'd0);
    chk("t6_op_stall", {31'd0, op_stall}, 32'd0);
    tick(); idle();

    // 7. MOV r0 <- r2 (A5), then OUT r0.
    op_valid = 1'b1; op_code = 2'b01; op_dst = 2'd0; op_src = 2'd2;
    pushWr(2'd0, 8'hA5);
    tick(); idle();
    op_valid = 1'b1; op_code = 2'b10; op_src = 2'd0;
    outQ.push_back(8'hA5);
    tick(); idle();

    repeat (3) tick();
    chk("wr_queue_drained", wrQ.size(), 32'd0);
    chk("out_queue_drained", outQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
